// File: rtl/accel_stream_arbiter.sv
// Packet-level round-robin arbiter that merges NUM_SRC AXI4-Stream sources onto one registered master port.
// The grant is held for a whole packet; runaway packets are cut at MAX_BEATS and flagged in err_trunc.
module accel_stream_arbiter #(
  parameter int unsigned NUM_SRC   = 4,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ID_W      = 8,
  parameter int unsigned DEST_W    = 4,
  parameter int unsigned USER_W    = 8,
  parameter int unsigned MAX_BEATS = 10
) (
  input  logic                         ACLK,
  input  logic                         ARESET,
  input  logic [NUM_SRC-1:0]           src_en,
  input  logic                         clr_err,
  input  logic [NUM_SRC-1:0]           s_tvalid,
  output logic [NUM_SRC-1:0]           s_tready,
  input  logic [NUM_SRC*DATA_W-1:0]    s_tdata,
  input  logic [NUM_SRC*DATA_W/8-1:0]  s_tkeep,
  input  logic [NUM_SRC*DEST_W-1:0]    s_tdest,
  input  logic [NUM_SRC*USER_W-1:0]    s_tuser,
  input  logic [NUM_SRC-1:0]           s_tlast,
  output logic                         m_tvalid,
  input  logic                         m_tready,
  output logic [DATA_W-1:0]            m_tdata,
  output logic [DATA_W/8-1:0]          m_tkeep,
  output logic [ID_W-1:0]              m_tid,
  output logic [DEST_W-1:0]            m_tdest,
  output logic [USER_W-1:0]            m_tuser,
  output logic                         m_tlast,
  output logic                         busy,
  output logic [15:0]                  pkt_count,
  output logic                         err_trunc
);

  localparam int unsigned KEEP_W = DATA_W / 8;
  localparam int unsigned IDX_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int unsigned CNT_W  = $clog2(MAX_BEATS + 1);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t               state, next_state;
  logic [IDX_W-1:0]     grant, rr_ptr, pick, next_ptr;
  logic                 pick_vld;
  logic [NUM_SRC-1:0]   req;
  logic [CNT_W-1:0]     beat_cnt;
  logic                 out_ready, accept, beat_last, forced;

  // Round-robin search starting at rr_ptr; first requesting index wins.
  always_comb begin
    int unsigned idx;
    req      = s_tvalid & src_en;
    pick     = '0;
    pick_vld = 1'b0;
    idx      = 0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      idx = (32'(rr_ptr) + k) % NUM_SRC;
      if (!pick_vld && req[IDX_W'(idx)]) begin
        pick     = IDX_W'(idx);
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    out_ready = !m_tvalid || m_tready;
    accept    = s_tvalid[grant] && s_tready[grant];
    beat_last = s_tlast[grant] || (beat_cnt == CNT_W'(MAX_BEATS - 1));
    forced    = accept && beat_last && !s_tlast[grant];
    next_ptr  = (grant == IDX_W'(NUM_SRC - 1)) ? '0 : grant + 1'b1;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (pick_vld) next_state = LOCK;
      LOCK:    if (accept && beat_last) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    s_tready = '0;
    busy     = (state == LOCK);
    if (state == LOCK) s_tready[grant] = out_ready;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      grant     <= '0;
      rr_ptr    <= '0;
      beat_cnt  <= '0;
      m_tvalid  <= 1'b0;
      m_tdata   <= '0;
      m_tkeep   <= '0;
      m_tid     <= '0;
      m_tdest   <= '0;
      m_tuser   <= '0;
      m_tlast   <= 1'b0;
      pkt_count <= '0;
      err_trunc <= 1'b0;
    end else begin
      if (state == IDLE && pick_vld) grant <= pick;
      if (accept) begin
        if (beat_last) begin
          beat_cnt <= '0;
          rr_ptr   <= next_ptr;
        end else begin
          beat_cnt <= beat_cnt + 1'b1;
        end
      end
      if (out_ready) begin
        m_tvalid <= accept;
        if (accept) begin
          m_tdata <= s_tdata[grant*DATA_W +: DATA_W];
          m_tkeep <= s_tkeep[grant*KEEP_W +: KEEP_W];
          m_tdest <= s_tdest[grant*DEST_W +: DEST_W];
          m_tuser <= s_tuser[grant*USER_W +: USER_W];
          m_tid   <= ID_W'(grant);
          m_tlast <= beat_last;
        end
      end
      if (m_tvalid && m_tready && m_tlast) pkt_count <= pkt_count + 1'b1;
      // A truncation in the same cycle as clr_err must stay visible.
      if (forced)       err_trunc <= 1'b1;
      else if (clr_err) err_trunc <= 1'b0;
    end
  end

endmodule

// File: tb/tb_accel_stream_arbiter.sv
// Directed bench for accel_stream_arbiter: scripted per-source packet lists, master beats captured
// with their cycle stamp and compared against hand-computed sequences.
module tb_accel_stream_arbiter;
  localparam int NS = 4, DW = 32, IW = 8, DSW = 4, UW = 8, MB = 10, DEPTH = 40;

  logic              ACLK = 1'b0;
  logic              ARESET, clr_err, m_tready;
  logic [NS-1:0]     src_en, s_tvalid, s_tready, s_tlast;
  logic [NS*DW-1:0]  s_tdata;
  logic [NS*4-1:0]   s_tkeep;
  logic [NS*DSW-1:0] s_tdest;
  logic [NS*UW-1:0]  s_tuser;
  logic              m_tvalid, m_tlast, busy, err_trunc;
  logic [DW-1:0]     m_tdata;
  logic [3:0]        m_tkeep;
  logic [IW-1:0]     m_tid;
  logic [DSW-1:0]    m_tdest;
  logic [UW-1:0]     m_tuser;
  logic [15:0]       pkt_count;

  accel_stream_arbiter #(.NUM_SRC(NS), .DATA_W(DW), .ID_W(IW), .DEST_W(DSW), .USER_W(UW), .MAX_BEATS(MB)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .src_en(src_en), .clr_err(clr_err),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tkeep(s_tkeep),
    .s_tdest(s_tdest), .s_tuser(s_tuser), .s_tlast(s_tlast),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tkeep(m_tkeep),
    .m_tid(m_tid), .m_tdest(m_tdest), .m_tuser(m_tuser), .m_tlast(m_tlast),
    .busy(busy), .pkt_count(pkt_count), .err_trunc(err_trunc)
  );

  always #5 ACLK = ~ACLK;

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  id;
    logic        last;
    logic [3:0]  keep;
    logic [3:0]  dest;
    logic [7:0]  user;
    logic [31:0] cyc;
  } cap_t;

  cap_t        caps[$];
  logic [31:0] sd [NS][DEPTH];
  logic        sl [NS][DEPTH];
  int unsigned slen [NS];
  int unsigned sptr [NS];
  int          n_pass = 0, n_checks = 0;
  logic [31:0] cyc = 0;
  bit          clr_at_trunc = 0;
  logic        snap_valid, snap_ready, snap_last, snap_busy;
  logic [31:0] snap_data;
  logic [7:0]  snap_id;
  logic [NS-1:0] snap_sready;

  task automatic clr_src();
    for (int s = 0; s < NS; s++) begin
      slen[s] = 0;
      sptr[s] = 0;
    end
  endtask

  task automatic add_pkt(input int s, input int n, input logic [31:0] d0);
    for (int b = 0; b < n; b++) begin
      sd[s][slen[s]] = d0 + 32'(b);
      sl[s][slen[s]] = (b == n - 1);
      slen[s]++;
    end
  endtask

  // One clock: drive at negedge, sample #1 later, advance source pointers on handshakes.
  task automatic step(input logic rdy);
    logic [NS-1:0] hs;
    cap_t c;
    for (int s = 0; s < NS; s++) begin
      if (sptr[s] < slen[s]) begin
        s_tvalid[s]            = 1'b1;
        s_tdata[s*DW +: DW]    = sd[s][sptr[s]];
        s_tkeep[s*4 +: 4]      = sd[s][sptr[s]][3:0];
        s_tdest[s*DSW +: DSW]  = 4'(s);
        s_tuser[s*UW +: UW]    = sd[s][sptr[s]][7:0] ^ 8'h5A;
        s_tlast[s]             = sl[s][sptr[s]];
      end else begin
        s_tvalid[s] = 1'b0;
        s_tlast[s]  = 1'b0;
      end
    end
    m_tready = rdy;
    #1;
    snap_valid = m_tvalid; snap_ready = m_tready; snap_data = m_tdata; snap_last = m_tlast;
    snap_id = m_tid; snap_sready = s_tready; snap_busy = busy;
    hs = s_tvalid & s_tready;
    if (m_tvalid && m_tready) begin
      c.data = m_tdata; c.id = m_tid; c.last = m_tlast; c.keep = m_tkeep;
      c.dest = m_tdest; c.user = m_tuser; c.cyc = cyc;
      caps.push_back(c);
    end
    if (clr_at_trunc && hs[1] && sptr[1] == 9) clr_err = 1'b1;
    @(posedge ACLK);
    cyc++;
    for (int s = 0; s < NS; s++) if (hs[s]) sptr[s]++;
    @(negedge ACLK);
    if (clr_at_trunc) clr_err = 1'b0;
  endtask

  task automatic run_until(input int n, input int budget, output bit ok);
    int k = 0;
    while (caps.size() < n && k < budget) begin
      step(1'b1);
      k++;
    end
    ok = (caps.size() >= n);
  endtask

  task automatic do_reset();
    ARESET = 1'b1; clr_err = 1'b0; src_en = '0;
    clr_src();
    repeat (3) step(1'b1);
    caps.delete();
    ARESET = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({m_tvalid, m_tlast, busy, err_trunc} !== 4'b0000) $display("FAIL reset_flags got=%b exp=0000", {m_tvalid, m_tlast, busy, err_trunc});
    else n_pass++;
    n_checks++;
    if (m_tdata !== '0 || m_tid !== '0 || m_tkeep !== '0 || m_tdest !== '0 || m_tuser !== '0)
      $display("FAIL reset_payload got data=%h id=%h keep=%h dest=%h user=%h exp=0", m_tdata, m_tid, m_tkeep, m_tdest, m_tuser);
    else n_pass++;
    n_checks++;
    if (pkt_count !== 16'd0) $display("FAIL reset_pkt_count got=%0d exp=0", pkt_count); else n_pass++;
    src_en = 4'hF;
    add_pkt(0, 1, 32'h5);
    step(1'b1);
    n_checks++;
    if (snap_sready !== 4'b0000 || snap_busy !== 1'b0) $display("FAIL idle_bubble got sready=%b busy=%b exp=0000/0", snap_sready, snap_busy);
    else n_pass++;
    step(1'b1);
    n_checks++;
    if (snap_sready !== 4'b0001 || snap_busy !== 1'b1) $display("FAIL lock_ready got sready=%b busy=%b exp=0001/1", snap_sready, snap_busy);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    bit ok;
    do_reset();
    src_en = 4'hF;
    for (int s = 0; s < NS; s++) add_pkt(s, 3, 32'(s * 3 + 1));
    run_until(12, 100, ok);
    n_checks++;
    if (!ok) $display("FAIL rr_timeout got=%0d beats exp=12", caps.size()); else n_pass++;
    for (int i = 0; i < 12; i++) begin
      n_checks++;
      if (caps[i].id !== 8'(i / 3) || caps[i].data !== 32'(i + 1) || caps[i].last !== (i % 3 == 2) ||
          caps[i].dest !== 4'(i / 3) || caps[i].keep !== 4'(i + 1) || caps[i].user !== (8'(i + 1) ^ 8'h5A))
        $display("FAIL rr_beat%0d got id=%0d data=%h last=%b dest=%0d keep=%h user=%h exp id=%0d data=%h last=%b",
                 i, caps[i].id, caps[i].data, caps[i].last, caps[i].dest, caps[i].keep, caps[i].user, i / 3, i + 1, i % 3 == 2);
      else n_pass++;
    end
    for (int i = 1; i < 12; i++) begin
      n_checks++;
      if (caps[i].cyc - caps[i-1].cyc !== ((i % 3 == 0) ? 32'd2 : 32'd1))
        $display("FAIL rr_gap%0d got=%0d exp=%0d", i, caps[i].cyc - caps[i-1].cyc, (i % 3 == 0) ? 2 : 1);
      else n_pass++;
    end
    repeat (2) step(1'b1);
    n_checks++;
    if (pkt_count !== 16'd4) $display("FAIL rr_pkt_count got=%0d exp=4", pkt_count); else n_pass++;
  endtask

  task automatic test_truncation();
    bit ok;
    do_reset();
    src_en = 4'hF;
    add_pkt(1, 14, 32'h1);
    run_until(14, 100, ok);
    repeat (2) step(1'b1);
    n_checks++;
    if (!ok) $display("FAIL trunc_timeout got=%0d beats exp=14", caps.size()); else n_pass++;
    for (int i = 0; i < 14; i++) begin
      n_checks++;
      if (caps[i].id !== 8'd1 || caps[i].data !== 32'(i + 1) || caps[i].last !== (i == 9 || i == 13))
        $display("FAIL trunc_beat%0d got id=%0d data=%h last=%b exp id=1 data=%h last=%b",
                 i, caps[i].id, caps[i].data, caps[i].last, i + 1, i == 9 || i == 13);
      else n_pass++;
    end
    n_checks++;
    if (err_trunc !== 1'b1 || pkt_count !== 16'd2) $display("FAIL trunc_status got err=%b pkts=%0d exp err=1 pkts=2", err_trunc, pkt_count);
    else n_pass++;
    clr_err = 1'b1;
    step(1'b1);
    clr_err = 1'b0;
    n_checks++;
    if (err_trunc !== 1'b0) $display("FAIL trunc_clear got=%b exp=0", err_trunc); else n_pass++;
    do_reset();
    src_en = 4'hF;
    add_pkt(1, 11, 32'h20);
    clr_at_trunc = 1;
    run_until(11, 100, ok);
    clr_at_trunc = 0;
    repeat (2) step(1'b1);
    n_checks++;
    if (!ok || caps[9].last !== 1'b1 || caps[10].last !== 1'b1) $display("FAIL trunc2_last got n=%0d last9=%b last10=%b exp 11/1/1", caps.size(), caps[9].last, caps[10].last);
    else n_pass++;
    n_checks++;
    if (err_trunc !== 1'b1) $display("FAIL trunc_beats_clear got=%b exp=1", err_trunc); else n_pass++;
  endtask

  task automatic test_stall();
    logic [15:0] pat = 16'b1001_0110_1100_1001;
    logic pv, pl; logic [31:0] pd; logic [7:0] pid;
    bit prev_stall = 0;
    int extra = 0;
    do_reset();
    src_en = 4'hF;
    add_pkt(0, 8, 32'h1);
    for (int k = 0; k < 80; k++) begin
      step(pat[k % 16]);
      if (prev_stall) begin
        n_checks++;
        if ({snap_valid, snap_data, snap_last, snap_id} !== {pv, pd, pl, pid})
          $display("FAIL stall_hold cyc%0d got v=%b d=%h l=%b id=%0d exp v=%b d=%h l=%b id=%0d", k, snap_valid, snap_data, snap_last, snap_id, pv, pd, pl, pid);
        else n_pass++;
      end
      prev_stall = snap_valid && !snap_ready;
      pv = snap_valid; pd = snap_data; pl = snap_last; pid = snap_id;
      if (caps.size() >= 8) extra++;
      if (extra > 6) break;
    end
    n_checks++;
    if (caps.size() != 8) $display("FAIL stall_count got=%0d exp=8", caps.size()); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (caps[i].data !== 32'(i + 1) || caps[i].last !== (i == 7) || caps[i].id !== 8'd0)
        $display("FAIL stall_beat%0d got data=%h last=%b id=%0d exp data=%h last=%b id=0", i, caps[i].data, caps[i].last, caps[i].id, i + 1, i == 7);
      else n_pass++;
    end
  endtask

  task automatic test_mask();
    bit ok;
    logic [31:0] ed;
    do_reset();
    src_en = 4'b0101;
    for (int s = 0; s < NS; s++) begin
      add_pkt(s, 2, 32'(s * 256 + 16));
      add_pkt(s, 2, 32'(s * 256 + 32));
    end
    run_until(8, 100, ok);
    repeat (6) step(1'b1);
    n_checks++;
    if (caps.size() != 8) $display("FAIL mask_count got=%0d exp=8", caps.size()); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      ed = 32'(((i / 2) % 2) * 2 * 256 + (i / 4) * 16 + 16 + i % 2);
      n_checks++;
      if (caps[i].id !== 8'(((i / 2) % 2) * 2) || caps[i].data !== ed || caps[i].last !== (i % 2 == 1))
        $display("FAIL mask_beat%0d got id=%0d data=%h last=%b exp id=%0d data=%h last=%b", i, caps[i].id, caps[i].data, caps[i].last, ((i / 2) % 2) * 2, ed, i % 2 == 1);
      else n_pass++;
    end
    do_reset();
    src_en = 4'b0101;
    add_pkt(0, 4, 32'h40);
    add_pkt(0, 2, 32'h50);
    add_pkt(2, 2, 32'h60);
    run_until(1, 20, ok);
    src_en = 4'b0100;
    run_until(6, 60, ok);
    repeat (6) step(1'b1);
    n_checks++;
    if (caps.size() != 6) $display("FAIL mask_mid_count got=%0d exp=6", caps.size()); else n_pass++;
    for (int i = 0; i < 6; i++) begin
      ed = (i < 4) ? 32'(64 + i) : 32'(96 + i - 4);
      n_checks++;
      if (caps[i].id !== ((i < 4) ? 8'd0 : 8'd2) || caps[i].data !== ed || caps[i].last !== (i == 3 || i == 5))
        $display("FAIL mask_mid_beat%0d got id=%0d data=%h last=%b exp id=%0d data=%h", i, caps[i].id, caps[i].data, caps[i].last, (i < 4) ? 0 : 2, ed);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    src_en = 4'hF;
    add_pkt(2, 1, 32'h77);
    run_until(1, 20, ok);
    repeat (2) step(1'b1);
    caps.delete();
    add_pkt(0, 5, 32'h80);
    run_until(2, 20, ok);
    n_checks++;
    if (!ok || pkt_count !== 16'd1) $display("FAIL rmid_setup got beats=%0d pkts=%0d exp 2/1", caps.size(), pkt_count); else n_pass++;
    ARESET = 1'b1;
    step(1'b1);
    n_checks++;
    if ({m_tvalid, m_tlast, busy, err_trunc} !== 4'b0000 || m_tdata !== '0 || m_tid !== '0 || s_tready !== '0)
      $display("FAIL rmid_outputs got v=%b l=%b busy=%b err=%b d=%h id=%0d sready=%b exp all 0", m_tvalid, m_tlast, busy, err_trunc, m_tdata, m_tid, s_tready);
    else n_pass++;
    n_checks++;
    if (pkt_count !== 16'd0) $display("FAIL rmid_pkt_count got=%0d exp=0", pkt_count); else n_pass++;
    ARESET = 1'b0;
    clr_src();
    caps.delete();
    add_pkt(3, 1, 32'h90);
    add_pkt(0, 1, 32'hA0);
    run_until(2, 30, ok);
    n_checks++;
    if (!ok || caps[0].id !== 8'd0 || caps[0].data !== 32'hA0 || caps[1].id !== 8'd3 || caps[1].data !== 32'h90)
      $display("FAIL rmid_rr_restart got id0=%0d d0=%h id1=%0d d1=%h exp 0/a0 3/90", caps[0].id, caps[0].data, caps[1].id, caps[1].data);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    bit ok;
    do_reset();
    src_en = 4'hF;
    for (int p = 0; p < 5; p++) add_pkt(3, 1, 32'(176 + p));
    run_until(5, 40, ok);
    n_checks++;
    if (!ok) $display("FAIL b2b_timeout got=%0d beats exp=5", caps.size()); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (caps[i].id !== 8'd3 || caps[i].last !== 1'b1 || caps[i].data !== 32'(176 + i))
        $display("FAIL b2b_beat%0d got id=%0d last=%b data=%h exp id=3 last=1 data=%h", i, caps[i].id, caps[i].last, caps[i].data, 176 + i);
      else n_pass++;
      if (i > 0) begin
        n_checks++;
        if (caps[i].cyc - caps[i-1].cyc !== 32'd2) $display("FAIL b2b_gap%0d got=%0d exp=2", i, caps[i].cyc - caps[i-1].cyc);
        else n_pass++;
      end
    end
  endtask

  initial begin
    ARESET = 1'b1; clr_err = 1'b0; src_en = '0; m_tready = 1'b0;
    s_tvalid = '0; s_tdata = '0; s_tkeep = '0; s_tdest = '0; s_tuser = '0; s_tlast = '0;
    clr_src();
    @(negedge ACLK);
    test_reset();
    test_round_robin();
    test_truncation();
    test_stall();
    test_mask();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/accel_stream_arbiter.md
Name: accel_stream_arbiter

Overview:
- Packet-level round-robin arbiter that shares the Accelerator's single AXI4-Stream master output among NUM_SRC internal stream sources.
- Grant is locked from a packet's first beat until its TLAST. Output TID carries the granted source index.
- Per-source enables and error clear come from AXI4-Lite control registers; packet count and truncation status go back to them.
- A MAX_BEATS guard force-terminates runaway packets.

Parameters:
- NUM_SRC, 4, number of requesting stream sources (2..8).
- DATA_W, 32, TDATA width.
- ID_W, 8, TID width; must hold NUM_SRC-1.
- DEST_W, 4, TDEST width.
- USER_W, 8, TUSER width.
- MAX_BEATS, 10, maximum beats per output packet.

Ports:
- ACLK  in  1  clock.
- ARESET  in  1  synchronous active-high reset.
- src_en  in  NUM_SRC  per-source enable (AXI-Lite reg).
- clr_err  in  1  one-cycle pulse, clears err_trunc.
- s_tvalid  in  NUM_SRC  source valid.
- s_tready  out  NUM_SRC  source ready.
- s_tdata  in  NUM_SRC*DATA_W  source data, source i at [i*DATA_W +: DATA_W].
- s_tkeep  in  NUM_SRC*DATA_W/8  byte keep.
- s_tdest  in  NUM_SRC*DEST_W  destination.
- s_tuser  in  NUM_SRC*USER_W  user sideband.
- s_tlast  in  NUM_SRC  end of packet.
- m_tvalid  out  1  master valid.
- m_tready  in  1  master ready.
- m_tdata  out  DATA_W.
- m_tkeep  out  DATA_W/8.
- m_tid  out  ID_W  granted source index, zero-extended.
- m_tdest  out  DEST_W.
- m_tuser  out  USER_W.
- m_tlast  out  1.
- busy  out  1  grant locked.
- pkt_count  out  16  packets completed on master, wraps at 0xFFFF->0.
- err_trunc  out  1  sticky: a packet was force-terminated.

Behaviour:
- Clock and reset: one clock ACLK; synchronous active-high reset ARESET.
- Reset values:
  - All m_* outputs, s_tready, busy, pkt_count and err_trunc are 0.
  - rr_ptr = 0, beat_cnt = 0, state = IDLE.
  - Reset asserted mid-packet discards the in-flight beat; no TLAST is emitted.
- Output register: m_* is a single register stage and updates only when !m_tvalid || m_tready.
  - Source-to-master latency is 1 cycle.
  - m_* holds stable while m_tvalid && !m_tready.
- FSM IDLE:
  - req = s_tvalid & src_en.
  - If req != 0, grant = first set bit searching rr_ptr, rr_ptr+1, ... modulo NUM_SRC; set busy = 1; go to LOCK.
  - s_tready is all 0 in IDLE, so there is a 1-cycle arbitration bubble per packet.
- FSM LOCK:
  - s_tready[grant] = !m_tvalid || m_tready; all other bits are 0.
  - A beat is accepted when s_tvalid[grant] && s_tready[grant]; it loads the output register and beat_cnt increments.
  - m_tlast = s_tlast[grant] || (beat_cnt == MAX_BEATS-1).
- Truncation:
  - A forced TLAST without source TLAST sets err_trunc.
  - The remaining beats of that source form a new packet that competes again through IDLE.
- End of packet:
  - The beat carrying m_tlast is accepted into the output register.
  - Then beat_cnt = 0, rr_ptr = grant+1 mod NUM_SRC, busy = 0, next state IDLE.
- pkt_count increments when m_tvalid && m_tready && m_tlast.
- src_en deasserted mid-packet does not break the lock; the packet completes. It only masks the next arbitration.
- A source that is granted but drops s_tvalid stalls the arbiter. There is no timeout and no other source is served.
- clr_err clears err_trunc. A truncation in the same cycle as clr_err wins, leaving err_trunc = 1.
- m_tid = grant for every beat of the packet.

Test Plan:
- All four sources enabled, each sends 3-beat packets, TDATA 0x01..0x0C, m_tready = 1 -> m_tid order 0,1,2,3,0,...; beats contiguous per packet; pkt_count = 4 after first round; one bubble cycle between packets.
- Source 1 sends 14 beats with TLAST only on beat 14, MAX_BEATS = 10 -> packet of 10 beats with m_tlast on beat 10, then a 4-beat packet; err_trunc = 1; clr_err pulse -> err_trunc = 0.
- m_tready toggles 1,0,0,1 pseudo-randomly during a packet of 0x01..0x08 -> data out 0x01..0x08 in order, no loss or duplication, m_* stable while stalled.
- src_en = 4'b0101 with all sources valid -> only m_tid 0 and 2 appear, alternating; clear src_en[0] mid-packet -> current packet still completes.
- ARESET pulsed in cycle 2 of a 5-beat packet -> next cycle all outputs 0, pkt_count 0, rr_ptr 0; after release, source 0 arbitrates first.
- Only source 3 active, back-to-back 1-beat packets -> every packet granted to 3, m_tlast on every beat, throughput 1 beat per 2 cycles.
